// File: rtl/float_pkg.sv
// Shared float format constants and helpers, used by the multiplier and the
// adder/normaliser path. Widths derive from the exponent/mantissa field sizes.
package float_pkg;
   localparam int EXP_W_DEF = 7;
   localparam int MAN_W_DEF = 16;

   // Bit positions within the 2-bit flag vector carried alongside a result
   localparam int FLAG_OVF = 0;
   localparam int FLAG_UNF = 1;
   localparam int FLAG_W   = 2;

   function automatic int word_w(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   function automatic int bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction
endpackage

// File: rtl/float_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined float multiplier.
interface float_mul_pipe_if import float_pkg::*; #(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF
);
   localparam int W = word_w(EXP_W, MAN_W);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_ovf;
   logic         out_unf;

   modport master (output in_valid, in_a, in_b, out_ready,
                   input  in_ready, out_valid, out_data, out_ovf, out_unf);
   modport slave  (input  in_valid, in_a, in_b, out_ready,
                   output in_ready, out_valid, out_data, out_ovf, out_unf);
endinterface

// File: rtl/float_round.sv
// Normalise a raw mantissa product and round it to nearest-even.
// Exponent comes back adjusted for the normalise shift and any rounding carry.
module float_round import float_pkg::*; #(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF
) (
   input  logic [2*MAN_W-1:0]      prod_i,
   input  logic signed [EXP_W+1:0] exp_i,
   output logic [MAN_W-1:0]        man_o,
   output logic signed [EXP_W+1:0] exp_o
);
   localparam int EW = EXP_W + 2;

   logic               hi, guard, sticky, up;
   logic [2*MAN_W-1:0] norm;
   logic [MAN_W-1:0]   kept;
   logic [MAN_W:0]     sum;

   always_comb begin
      hi     = prod_i[2*MAN_W-1];
      // Left-align so kept/guard/sticky sit at fixed positions in both cases
      norm   = hi ? prod_i : (prod_i << 1);
      kept   = norm[2*MAN_W-1 -: MAN_W];
      guard  = norm[MAN_W-1];
      sticky = |norm[MAN_W-2:0];
      up     = guard & (sticky | kept[0]);
      sum    = {1'b0, kept} + {{MAN_W{1'b0}}, up};
      man_o  = sum[MAN_W] ? sum[MAN_W:1] : sum[MAN_W-1:0];
      exp_o  = exp_i + EW'(hi) + EW'(sum[MAN_W]);
   end
endmodule

// File: rtl/float_mul_pipe.sv
// Three-stage float multiplier: S1 multiply/exponent add, S2 normalise/round,
// S3 saturate/flush and registered outputs. Elastic valid/ready at each stage.
module float_mul_pipe import float_pkg::*; #(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF
) (
   input logic             clk,
   input logic             rst,
   float_mul_pipe_if.slave bus
);
   localparam int W    = word_w(EXP_W, MAN_W);
   localparam int EW   = EXP_W + 2;
   localparam logic signed [EW-1:0] BIAS_S = EW'(bias(EXP_W));
   localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EMIN   = EW'(1);

   logic [3:1]         vld_q;
   logic               en1, en2, en3;
   logic [EXP_W-1:0]   ea, eb;

   logic               sgn1_d, zero1_d, sgn1_q, zero1_q;
   logic signed [EW-1:0] exp1_d, exp1_q;
   logic [2*MAN_W-1:0] prod1_d, prod1_q;

   logic               sgn2_q, zero2_q;
   logic [MAN_W-1:0]   man2_d, man2_q;
   logic signed [EW-1:0] exp2_d, exp2_q;

   logic [W-1:0]       data_d, data_q;
   logic [FLAG_W-1:0]  flags_d, flags_q;

   // A stage may load when it is empty or its contents are moving on
   always_comb begin
      en3 = !vld_q[3] || bus.out_ready;
      en2 = !vld_q[2] || en3;
      en1 = !vld_q[1] || en2;
   end

   assign bus.in_ready  = rst && en1;
   assign bus.out_valid = vld_q[3];
   assign bus.out_data  = data_q;
   assign bus.out_ovf   = flags_q[FLAG_OVF];
   assign bus.out_unf   = flags_q[FLAG_UNF];

   always_comb begin
      ea      = bus.in_a[W-2:MAN_W];
      eb      = bus.in_b[W-2:MAN_W];
      sgn1_d  = bus.in_a[W-1] ^ bus.in_b[W-1];
      zero1_d = (ea == '0) || (eb == '0);
      exp1_d  = EW'(ea) + EW'(eb) - BIAS_S;
      prod1_d = (2*MAN_W)'(bus.in_a[MAN_W-1:0]) * (2*MAN_W)'(bus.in_b[MAN_W-1:0]);
   end

   float_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
      .prod_i(prod1_q),
      .exp_i (exp1_q),
      .man_o (man2_d),
      .exp_o (exp2_d)
   );

   always_comb begin
      data_d  = '0;
      flags_d = '0;
      if (zero2_q) begin
         data_d = {sgn2_q, {(W-1){1'b0}}};
      end else if (exp2_q > EMAX) begin
         data_d            = {sgn2_q, {(W-1){1'b1}}};
         flags_d[FLAG_OVF] = 1'b1;
      end else if (exp2_q < EMIN) begin
         data_d            = {sgn2_q, {(W-1){1'b0}}};
         flags_d[FLAG_UNF] = 1'b1;
      end else begin
         data_d = {sgn2_q, exp2_q[EXP_W-1:0], man2_q};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q   <= '0;
         sgn1_q  <= 1'b0;
         zero1_q <= 1'b0;
         exp1_q  <= '0;
         prod1_q <= '0;
         sgn2_q  <= 1'b0;
         zero2_q <= 1'b0;
         man2_q  <= '0;
         exp2_q  <= '0;
         data_q  <= '0;
         flags_q <= '0;
      end else begin
         if (en1) vld_q[1] <= bus.in_valid;
         if (en1 && bus.in_valid) begin
            sgn1_q  <= sgn1_d;
            zero1_q <= zero1_d;
            exp1_q  <= exp1_d;
            prod1_q <= prod1_d;
         end
         if (en2) vld_q[2] <= vld_q[1];
         if (en2 && vld_q[1]) begin
            sgn2_q  <= sgn1_q;
            zero2_q <= zero1_q;
            man2_q  <= man2_d;
            exp2_q  <= exp2_d;
         end
         if (en3) vld_q[3] <= vld_q[2];
         if (en3 && vld_q[2]) begin
            data_q  <= data_d;
            flags_q <= flags_d;
         end
      end
   end
endmodule

// File: tb/tb_float_mul_pipe.sv
// Directed bench for float_mul_pipe at default widths: hand-computed products,
// latency, backpressure ordering/stability and mid-flight reset.
module tb_float_mul_pipe;
   import float_pkg::*;
   localparam int EXP_W = 7;
   localparam int MAN_W = 16;
   localparam int W     = 24;

   typedef struct {
      logic [W-1:0] a, b, y;
      logic         ovf, unf;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   vec_t vecs[$];

   float_mul_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
   float_mul_pipe    #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One isolated transfer; result must appear in the third cycle after it
   task automatic latency_check(input vec_t v, input string tag);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_a = v.a; bus.in_b = v.b; bus.out_ready = 1'b1;
      #1 check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
         @(posedge clk);
      end
      @(negedge clk);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_data"},  32'(bus.out_data),  32'(v.y));
      check({tag, "_ovf"},   32'(bus.out_ovf),   32'(v.ovf));
      check({tag, "_unf"},   32'(bus.out_unf),   32'(v.unf));
      @(posedge clk); #1;
   endtask

   // Feed n pairs back-to-back; scoreboard checks order, hold and in_ready
   task automatic run_stream(input int n, input bit rnd, input string tag);
      vec_t sb[$];
      vec_t v;
      int   sent = 0;
      int   cyc  = 0;
      bit   held = 1'b0;
      logic [W+1:0] held_d = '0;
      logic exp_rdy;
      while ((sent < n || sb.size() != 0) && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (held) begin
            check({tag, "_hold_v"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_d"}, 32'({bus.out_ovf, bus.out_unf, bus.out_data}), 32'(held_d));
         end
         bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.in_valid  = (sent < n);
         v = vecs[sent % vecs.size()];
         bus.in_a = v.a;
         bus.in_b = v.b;
         #1;
         exp_rdy = !(sb.size() == 3 && !bus.out_ready);
         check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
         held   = bus.out_valid && !bus.out_ready;
         held_d = {bus.out_ovf, bus.out_unf, bus.out_data};
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check({tag, "_spurious"}, 32'(bus.out_valid), 32'd0);
            end else begin
               v = sb.pop_front();
               check({tag, "_data"}, 32'(bus.out_data), 32'(v.y));
               check({tag, "_ovf"},  32'(bus.out_ovf),  32'(v.ovf));
               check({tag, "_unf"},  32'(bus.out_unf),  32'(v.unf));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back(vecs[sent % vecs.size()]);
            sent++;
         end
         @(posedge clk);
      end
      #1 bus.in_valid = 1'b0;
      check({tag, "_drained"}, 32'(sb.size()) + 32'(n - sent), 32'd0);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
      //                a           b           product     ovf   unf
      vecs.push_back('{24'h3FC000, 24'h3FC000, 24'h409000, 1'b0, 1'b0}); // 1.5*1.5
      vecs.push_back('{24'hBFC000, 24'h408000, 24'hC0C000, 1'b0, 1'b0}); // -1.5*2
      vecs.push_back('{24'h3F8001, 24'h3F8001, 24'h3F8002, 1'b0, 1'b0}); // round down
      vecs.push_back('{24'h7F8000, 24'h7F8000, 24'h7FFFFF, 1'b1, 1'b0}); // overflow
      vecs.push_back('{24'h018000, 24'h018000, 24'h000000, 1'b0, 1'b1}); // underflow
      vecs.push_back('{24'h000000, 24'h408000, 24'h000000, 1'b0, 1'b0}); // zero operand
      vecs.push_back('{24'h3F8001, 24'h3FC000, 24'h3FC002, 1'b0, 1'b0}); // tie, odd -> up
      vecs.push_back('{24'h3F8003, 24'h3FC000, 24'h3FC004, 1'b0, 1'b0}); // tie, even -> hold
      vecs.push_back('{24'h3FFFFE, 24'h3F8001, 24'h408000, 1'b0, 1'b0}); // rounding carry
      vecs.push_back('{24'h7F8000, 24'h3F8000, 24'h7F8000, 1'b0, 1'b0}); // max exponent
      vecs.push_back('{24'h208000, 24'h1F8000, 24'h000000, 1'b0, 1'b1}); // e = 0
      vecs.push_back('{24'h208000, 24'h208000, 24'h018000, 1'b0, 1'b0}); // e = 1
      vecs.push_back('{24'hFF8000, 24'h7F8000, 24'hFFFFFF, 1'b1, 1'b0}); // negative ovf
      vecs.push_back('{24'h800000, 24'h408000, 24'h800000, 1'b0, 1'b0}); // -0 * 2
      vecs.push_back('{24'h00ABCD, 24'h3FC000, 24'h000000, 1'b0, 1'b0}); // exp 0 ignores man

      #1 rst = 1'b0;
      #1;
      check("rst_in_ready",  32'(bus.in_ready),  32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      check("rst_ovf",       32'(bus.out_ovf),   32'd0);
      check("rst_unf",       32'(bus.out_unf),   32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      #1 check("rel_in_ready", 32'(bus.in_ready), 32'd1);

      latency_check(vecs[0], "lat0");
      run_stream(vecs.size(), 1'b0, "dir");
      run_stream(20, 1'b1, "bp");

      // Fill all three stages while stalled, then reset mid-flight
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.in_a = vecs[k].a;
         bus.in_b = vecs[k].b;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      check("fill_valid",    32'(bus.out_valid), 32'd1);
      check("fill_in_ready", 32'(bus.in_ready),  32'd0);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_valid",    32'(bus.out_valid), 32'd0);
      check("mid_rst_data",     32'(bus.out_data),  32'd0);
      check("mid_rst_flags",    32'({bus.out_ovf, bus.out_unf}), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready),  32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      bus.out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_stale", 32'(bus.out_valid), 32'd0);
      end
      latency_check(vecs[1], "lat1");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/float_mul_pipe.md
FLOAT_MUL_PIPE -- requirements
Module: float_mul_pipe

Interface
REQ-001 Parameter EXP_W, default 7: exponent field width, range 3..15.
REQ-002 Parameter MAN_W, default 16: mantissa field width, explicit leading one, range 4..32.
REQ-003 Derived constants: W = 1+EXP_W+MAN_W (default 24); BIAS = 2^(EXP_W-1)-1 (default 63).
REQ-004 Word format SHALL be sign [W-1], exponent [W-2:MAN_W], mantissa [MAN_W-1:0]; value = (-1)^s * (m/2^(MAN_W-1)) * 2^(e-BIAS).
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  operand pair present.
REQ-008 in_ready  out  1  block accepts the pair this cycle.
REQ-009 in_a, in_b  in  W  operands.
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  consumer accepts the result this cycle.
REQ-012 out_data  out  W  product.
REQ-013 out_ovf, out_unf  out  1 each  overflow-saturated / underflow-flushed flags, qualified by out_valid.

Function
REQ-014 Transfer SHALL occur on a rising edge where valid and ready are both high; a transfer is never lost or duplicated.
REQ-015 Pipeline SHALL have 3 stages: S1 multiply mantissas (2*MAN_W-bit product), add exponents, XOR signs, detect zero operands; S2 normalise and round; S3 saturate/flush, pack and register outputs.
REQ-016 Latency from input transfer to out_valid SHALL be 3 cycles with no backpressure; throughput 1 result per cycle.
REQ-017 Each stage SHALL advance when its successor is empty or advancing; bubbles SHALL collapse; in_ready = S1 empty or S1 advancing (combinational ready chain allowed).
REQ-018 While out_valid=1 and out_ready=0, out_data/out_ovf/out_unf SHALL hold stable.
REQ-019 Operand with exponent field 0 SHALL be treated as zero; result = sign XOR, exponent 0, mantissa 0, flags 0.
REQ-020 Normalise: if product bit [2*MAN_W-1] set, take upper MAN_W bits and add 1 to exponent; else take bits [2*MAN_W-2:MAN_W-1].
REQ-021 Rounding SHALL be round-to-nearest-even on the discarded bits; mantissa carry-out SHALL renormalise to 1000..0 and add 1 to exponent.
REQ-022 Exponent arithmetic SHALL use EXP_W+2-bit signed width: e = ea + eb - BIAS + adjustments.
REQ-023 e > 2^EXP_W-1: output sign, exponent all-ones, mantissa all-ones, out_ovf=1.
REQ-024 e < 1 (non-zero operands): output sign, exponent 0, mantissa 0, out_unf=1.
REQ-025 Input transfer and output transfer in the same cycle SHALL both complete, with no bubble inserted.

Reset
REQ-026 rst low SHALL immediately clear all stage valids, out_valid, out_data, out_ovf, out_unf to 0, discarding in-flight operations.
REQ-027 During reset in_ready SHALL be 0; after rst deasserts, in_ready SHALL be 1 from the first clock edge onward.

Structure
REQ-028 Field-width, BIAS and W derivations and flag bit positions SHALL live in shared package float_pkg, reused by the existing adder/normaliser path.
REQ-029 S2 normalise/round logic SHALL be a sub-module float_round (parameters EXP_W, MAN_W, purely combinational); stage registers stay in float_mul_pipe.

Verification (default parameters)
REQ-030 in_a=0x3FC000 (1.5), in_b=0x3FC000, out_ready=1 -> out_data=0x409000 (2.25) exactly 3 cycles later, flags 0.
REQ-031 in_a=0xBFC000 (-1.5), in_b=0x408000 (2.0) -> 0xC0C000 (-3.0); in_a=0x3F8001, in_b=0x3F8001 -> 0x3F8002 (round down).
REQ-032 in_a=in_b=0x7F8000 -> 0x7FFFFF, out_ovf=1; in_a=in_b=0x018000 -> 0x000000, out_unf=1; in_a=0x000000, in_b=0x408000 -> 0x000000, flags 0.
REQ-033 20 back-to-back pairs with out_ready toggled randomly -> outputs in order, none lost/duplicated, out_data stable while stalled, in_ready=0 only when all 3 stages full and stalled.
REQ-034 rst pulsed low with 3 operations in flight -> out_valid=0 immediately, no stale result after release; next pair yields correct result at latency 3.
